mfp_avalon_arbiter_2to1: RTL and testbench

- Shares the single Avalon-MM port of the LPDDR2 memory wrapper between two Avalon-MM masters. Master 0 is the CPU-side AHB-to-Avalon path; master 1 is a future DMA or video reader.
- Arbitration is round-robin. A grant is held for a whole write burst.
- Returned read data is steered to the master that issued the command, using an in-order tag FIFO.
- Sits between mfp_system's Avalon master port(s) and lpddr2_wrapper, in the avm_clk domain.

---
 rtl/mfp_avalon_arbiter_2to1.sv | 202 ++++++++++++++++++++
 tb/tb_mfp_avalon_arbiter_2to1.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mfp_avalon_arbiter_2to1.sv
// Two-master round-robin arbiter in front of the LPDDR2 Avalon-MM port.
// Write bursts hold the grant; read data is steered back through an in-order tag FIFO.
module mfp_avalon_arbiter_2to1 #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_WIDTH = 3,
  parameter int unsigned RD_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,

  input  logic [ADDR_WIDTH-1:0]   m0_address_i,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable_i,
  input  logic [BURST_WIDTH-1:0]  m0_burstcount_i,
  input  logic                    m0_read_i,
  input  logic                    m0_write_i,
  input  logic [DATA_WIDTH-1:0]   m0_writedata_i,
  output logic                    m0_waitrequest_o,
  output logic [DATA_WIDTH-1:0]   m0_readdata_o,
  output logic                    m0_readdatavalid_o,

  input  logic [ADDR_WIDTH-1:0]   m1_address_i,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable_i,
  input  logic [BURST_WIDTH-1:0]  m1_burstcount_i,
  input  logic                    m1_read_i,
  input  logic                    m1_write_i,
  input  logic [DATA_WIDTH-1:0]   m1_writedata_i,
  output logic                    m1_waitrequest_o,
  output logic [DATA_WIDTH-1:0]   m1_readdata_o,
  output logic                    m1_readdatavalid_o,

  output logic [ADDR_WIDTH-1:0]   s_address_o,
  output logic [DATA_WIDTH/8-1:0] s_byteenable_o,
  output logic [BURST_WIDTH-1:0]  s_burstcount_o,
  output logic [DATA_WIDTH-1:0]   s_writedata_o,
  output logic                    s_read_o,
  output logic                    s_write_o,
  output logic                    s_beginbursttransfer_o,
  input  logic                    s_waitrequest_i,
  input  logic                    s_readdatavalid_i,
  input  logic [DATA_WIDTH-1:0]   s_readdata_i
);

  localparam int unsigned PtrW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RD_DEPTH + 1);
  localparam int unsigned TagW = 1 + BURST_WIDTH;

  typedef enum logic [1:0] {StIdle, StGrant, StWburst} state_e;

  state_e                 state_q;
  logic                   owner_q;
  logic                   last_grant_q;
  logic                   first_q;
  logic [BURST_WIDTH-1:0] wcnt_q;

  logic                   req0, req1, grant_sel;
  logic                   own_read, own_write, own_wait, active;
  logic [BURST_WIDTH-1:0] own_bc, own_len;
  logic                   rd_accept, wr_accept;

  logic [TagW-1:0]        tag_mem [RD_DEPTH];
  logic [PtrW-1:0]        wptr_q, rptr_q;
  logic [CntW-1:0]        cnt_q;
  logic [BURST_WIDTH-1:0] rcnt_q;
  logic                   fifo_empty, fifo_full, rd_block;
  logic [TagW-1:0]        head;
  logic                   head_owner;
  logic [BURST_WIDTH-1:0] head_len;
  logic                   beat, push, pop;
  logic                   proto_err_q;

  // Arbitration and owner mux
  always_comb begin
    req0      = m0_read_i | m0_write_i;
    req1      = m1_read_i | m1_write_i;
    grant_sel = (req0 & req1) ? ~last_grant_q : req1;

    s_address_o    = owner_q ? m1_address_i    : m0_address_i;
    s_byteenable_o = owner_q ? m1_byteenable_i : m0_byteenable_i;
    s_writedata_o  = owner_q ? m1_writedata_i  : m0_writedata_i;
    own_bc         = owner_q ? m1_burstcount_i : m0_burstcount_i;
    own_read       = owner_q ? m1_read_i       : m0_read_i;
    own_write      = owner_q ? m1_write_i      : m0_write_i;
    s_burstcount_o = own_bc;
    own_len        = (own_bc == '0) ? BURST_WIDTH'(1) : own_bc;

    active                 = (state_q != StIdle);
    s_read_o               = (state_q == StGrant) & own_read & ~rd_block;
    s_write_o              = active & own_write;
    s_beginbursttransfer_o = (state_q == StGrant) & first_q;

    // A full tag FIFO only stalls reads; writes pass straight through.
    own_wait  = s_waitrequest_i | ((state_q == StGrant) & own_read & rd_block);
    rd_accept = s_read_o & ~s_waitrequest_i;
    wr_accept = s_write_o & ~s_waitrequest_i;

    m0_waitrequest_o = ~(active & ~owner_q) | own_wait;
    m1_waitrequest_o = ~(active &  owner_q) | own_wait;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      first_q      <= 1'b0;
      wcnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req0 | req1) begin
            owner_q <= grant_sel;
            first_q <= 1'b1;
            state_q <= StGrant;
          end
        end
        StGrant: begin
          first_q <= 1'b0;
          if (rd_accept) begin
            last_grant_q <= owner_q;
            state_q      <= StIdle;
          end else if (wr_accept) begin
            if (own_len == BURST_WIDTH'(1)) begin
              last_grant_q <= owner_q;
              state_q      <= StIdle;
            end else begin
              wcnt_q  <= own_len - BURST_WIDTH'(1);
              state_q <= StWburst;
            end
          end
        end
        StWburst: begin
          if (wr_accept) begin
            if (wcnt_q == BURST_WIDTH'(1)) begin
              last_grant_q <= owner_q;
              state_q      <= StIdle;
            end
            wcnt_q <= wcnt_q - BURST_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read-return steering from the head of the tag FIFO
  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == CntW'(RD_DEPTH));
    rd_block   = fifo_full;
    head       = tag_mem[rptr_q];
    head_owner = head[TagW-1];
    head_len   = (head[BURST_WIDTH-1:0] == '0) ? BURST_WIDTH'(1) : head[BURST_WIDTH-1:0];
    beat       = s_readdatavalid_i & ~fifo_empty;
    pop        = beat & (rcnt_q == head_len - BURST_WIDTH'(1));
    push       = rd_accept;

    m0_readdata_o      = s_readdata_i;
    m1_readdata_o      = s_readdata_i;
    m0_readdatavalid_o = beat & ~head_owner;
    m1_readdatavalid_o = beat &  head_owner;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wptr_q] <= {owner_q, own_bc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      rcnt_q      <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PtrW'(RD_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(RD_DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (beat) begin
        rcnt_q <= pop ? '0 : rcnt_q + BURST_WIDTH'(1);
      end
      if (s_readdatavalid_i & fifo_empty) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Sticky flag: the slave returned data nobody asked for.
  a_no_orphan_data: assert property (@(posedge clk) disable iff (!rst_n) !proto_err_q)
    else $error("readdatavalid seen with no outstanding read");

endmodule

// File: tb/tb_mfp_avalon_arbiter_2to1.sv
// Directed bench for mfp_avalon_arbiter_2to1: arbitration, burst hold, tag FIFO and reset.
module tb_mfp_avalon_arbiter_2to1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic [2:0]  m0_burstcount, m1_burstcount;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic [3:0]  s_byteenable;
  logic [2:0]  s_burstcount;
  logic        s_read, s_write, s_beginbursttransfer;
  logic        s_waitrequest, s_readdatavalid;

  int errors = 0;
  int checks = 0;

  mfp_avalon_arbiter_2to1 #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_WIDTH(3), .RD_DEPTH(4)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .m0_address_i           (m0_address),
    .m0_byteenable_i        (m0_byteenable),
    .m0_burstcount_i        (m0_burstcount),
    .m0_read_i              (m0_read),
    .m0_write_i             (m0_write),
    .m0_writedata_i         (m0_writedata),
    .m0_waitrequest_o       (m0_waitrequest),
    .m0_readdata_o          (m0_readdata),
    .m0_readdatavalid_o     (m0_readdatavalid),
    .m1_address_i           (m1_address),
    .m1_byteenable_i        (m1_byteenable),
    .m1_burstcount_i        (m1_burstcount),
    .m1_read_i              (m1_read),
    .m1_write_i             (m1_write),
    .m1_writedata_i         (m1_writedata),
    .m1_waitrequest_o       (m1_waitrequest),
    .m1_readdata_o          (m1_readdata),
    .m1_readdatavalid_o     (m1_readdatavalid),
    .s_address_o            (s_address),
    .s_byteenable_o         (s_byteenable),
    .s_burstcount_o         (s_burstcount),
    .s_writedata_o          (s_writedata),
    .s_read_o               (s_read),
    .s_write_o              (s_write),
    .s_beginbursttransfer_o (s_beginbursttransfer),
    .s_waitrequest_i        (s_waitrequest),
    .s_readdatavalid_i      (s_readdatavalid),
    .s_readdata_i           (s_readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF; m0_burstcount = 3'd1; m1_burstcount = 3'd1;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    s_waitrequest = 0; s_readdatavalid = 0; s_readdata = '0;

    // Reset values
    repeat (2) @(posedge clk);
    mid();
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_s_read", s_read, 0);
    chk("rst_s_write", s_write, 0);
    chk("rst_s_bbt", s_beginbursttransfer, 0);
    chk("rst_m0_rdv", m0_readdatavalid, 0);
    chk("rst_m1_rdv", m1_readdatavalid, 0);
    cyc();
    rst_n = 1'b1;

    // 1: m0 single read, two slave wait cycles, data three cycles after acceptance
    m0_address = 32'h100; m0_burstcount = 3'd1; m0_read = 1; s_waitrequest = 1;
    mid(); chk("t1_idle_sread", s_read, 0); chk("t1_idle_wait", m0_waitrequest, 1); cyc();
    mid(); chk("t1_sread", s_read, 1); chk("t1_addr", s_address, 32'h100);
    chk("t1_bbt", s_beginbursttransfer, 1); chk("t1_wait0", m0_waitrequest, 1); cyc();
    mid(); chk("t1_sread2", s_read, 1); chk("t1_bbt2", s_beginbursttransfer, 0); cyc();
    s_waitrequest = 0;
    mid(); chk("t1_acc_wait", m0_waitrequest, 0); chk("t1_m1_wait", m1_waitrequest, 1); cyc();
    m0_read = 0;
    mid(); chk("t1_one_cmd", s_read, 0); cyc();
    mid(); cyc();
    s_readdatavalid = 1; s_readdata = 32'hDEADBEEF;
    mid(); chk("t1_rdv", m0_readdatavalid, 1); chk("t1_rdata", m0_readdata, 32'hDEADBEEF);
    chk("t1_m1_rdv", m1_readdatavalid, 0); cyc();
    s_readdatavalid = 0;
    mid(); chk("t1_rdv_off", m0_readdatavalid, 0); cyc();

    // 2: both masters read together from reset
    rst_n = 0; cyc(); rst_n = 1;
    m0_address = 32'h200; m1_address = 32'h300; m0_read = 1; m1_read = 1;
    mid(); chk("t2_idle_sread", s_read, 0); cyc();
    mid(); chk("t2_first_addr", s_address, 32'h200); chk("t2_bbt1", s_beginbursttransfer, 1);
    chk("t2_m0_wait", m0_waitrequest, 0); chk("t2_m1_wait", m1_waitrequest, 1); cyc();
    m0_read = 0;
    mid(); chk("t2_gap_sread", s_read, 0); chk("t2_gap_bbt", s_beginbursttransfer, 0); cyc();
    mid(); chk("t2_second_addr", s_address, 32'h300); chk("t2_bbt2", s_beginbursttransfer, 1);
    chk("t2_m1_wait_lo", m1_waitrequest, 0); cyc();
    m1_read = 0; s_readdatavalid = 1; s_readdata = 32'h1111_1111;
    mid(); chk("t2_ret0_m0", m0_readdatavalid, 1); chk("t2_ret0_m1", m1_readdatavalid, 0); cyc();
    s_readdata = 32'h2222_2222;
    mid(); chk("t2_ret1_m1", m1_readdatavalid, 1); chk("t2_ret1_m0", m0_readdatavalid, 0);
    chk("t2_ret1_data", m1_readdata, 32'h2222_2222); cyc();
    s_readdatavalid = 0;

    // 3: m1 write burst of 4, m0 requests from beat 2
    m1_address = 32'h400; m1_burstcount = 3'd4; m1_writedata = 32'hD1; m1_write = 1;
    mid(); chk("t3_idle_swrite", s_write, 0); cyc();
    mid(); chk("t3_b1_write", s_write, 1); chk("t3_b1_data", s_writedata, 32'hD1);
    chk("t3_b1_bbt", s_beginbursttransfer, 1); chk("t3_b1_wait", m1_waitrequest, 0); cyc();
    m1_writedata = 32'hD2; m0_address = 32'h500; m0_burstcount = 3'd1; m0_read = 1;
    mid(); chk("t3_b2_data", s_writedata, 32'hD2); chk("t3_b2_bbt", s_beginbursttransfer, 0);
    chk("t3_b2_sread", s_read, 0); chk("t3_b2_m0wait", m0_waitrequest, 1); cyc();
    m1_writedata = 32'hD3;
    mid(); chk("t3_b3_data", s_writedata, 32'hD3); chk("t3_b3_sread", s_read, 0); cyc();
    m1_writedata = 32'hD4;
    mid(); chk("t3_b4_data", s_writedata, 32'hD4); chk("t3_b4_write", s_write, 1);
    chk("t3_b4_sread", s_read, 0); cyc();
    m1_write = 0;
    mid(); chk("t3_after_swrite", s_write, 0); chk("t3_after_sread", s_read, 0); cyc();
    mid(); chk("t3_m0_sread", s_read, 1); chk("t3_m0_addr", s_address, 32'h500);
    chk("t3_m0_bbt", s_beginbursttransfer, 1); cyc();
    m0_read = 0; s_readdatavalid = 1; s_readdata = 32'h33;
    mid(); chk("t3_m0_rdv", m0_readdatavalid, 1); cyc();
    s_readdatavalid = 0;

    // 4: five back-to-back m0 reads against a 4-deep tag FIFO
    m0_burstcount = 3'd1; m0_read = 1;
    for (int k = 0; k < 4; k++) begin
      m0_address = 32'h1000 + 32'(k * 4);
      mid(); chk("t4_idle_wait", m0_waitrequest, 1); cyc();
      mid(); chk("t4_sread", s_read, 1); chk("t4_addr", s_address, 32'h1000 + 32'(k * 4)); cyc();
    end
    m0_address = 32'h1010;
    mid(); cyc();
    mid(); chk("t4_full_sread", s_read, 0); chk("t4_full_wait", m0_waitrequest, 1); cyc();
    mid(); chk("t4_full_sread2", s_read, 0); chk("t4_full_wait2", m0_waitrequest, 1); cyc();
    s_readdatavalid = 1; s_readdata = 32'hA0;
    mid(); chk("t4_pop_rdv", m0_readdatavalid, 1); chk("t4_pop_sread", s_read, 0); cyc();
    s_readdatavalid = 0;
    mid(); chk("t4_5th_sread", s_read, 1); chk("t4_5th_wait", m0_waitrequest, 0);
    chk("t4_5th_addr", s_address, 32'h1010); cyc();
    m0_read = 0;
    for (int k = 0; k < 4; k++) begin
      s_readdatavalid = 1; s_readdata = 32'hB0 + 32'(k);
      mid(); chk("t4_drain_rdv", m0_readdatavalid, 1); chk("t4_drain_m1", m1_readdatavalid, 0); cyc();
    end
    s_readdatavalid = 0;

    // 5: m0 burst-2 read then m1 single read; returns A, B, C
    m0_address = 32'h600; m0_burstcount = 3'd2; m0_read = 1;
    mid(); cyc();
    mid(); chk("t5_m0_bc", s_burstcount, 3'd2); chk("t5_m0_sread", s_read, 1); cyc();
    m0_read = 0; m1_address = 32'h700; m1_burstcount = 3'd1; m1_read = 1;
    mid(); cyc();
    mid(); chk("t5_m1_addr", s_address, 32'h700); chk("t5_m1_bc", s_burstcount, 3'd1); cyc();
    m1_read = 0; s_readdatavalid = 1; s_readdata = 32'hAAAA;
    mid(); chk("t5_A_m0", m0_readdatavalid, 1); chk("t5_A_m1", m1_readdatavalid, 0); cyc();
    s_readdata = 32'hBBBB;
    mid(); chk("t5_B_m0", m0_readdatavalid, 1); chk("t5_B_m1", m1_readdatavalid, 0); cyc();
    s_readdata = 32'hCCCC;
    mid(); chk("t5_C_m1", m1_readdatavalid, 1); chk("t5_C_m0", m0_readdatavalid, 0);
    chk("t5_C_data", m1_readdata, 32'hCCCC); cyc();
    s_readdatavalid = 0;

    // burstcount 0 is a single beat
    m1_address = 32'h780; m1_burstcount = 3'd0; m1_write = 1;
    mid(); cyc();
    mid(); chk("t5_bc0_write", s_write, 1); cyc();
    mid(); chk("t5_bc0_done", s_write, 0); chk("t5_bc0_wait", m1_waitrequest, 1);
    m1_write = 0; cyc();

    // 6: reset during beat 2 of a 4-beat write, then a fresh burst
    m0_address = 32'h800; m0_burstcount = 3'd4; m0_writedata = 32'h1; m0_write = 1;
    mid(); cyc();
    mid(); chk("t6_b1_write", s_write, 1); cyc();
    m0_writedata = 32'h2;
    mid(); chk("t6_b2_write", s_write, 1); chk("t6_b2_data", s_writedata, 32'h2);
    #1 rst_n = 0;
    #1;
    chk("t6_rst_swrite", s_write, 0); chk("t6_rst_m0wait", m0_waitrequest, 1);
    chk("t6_rst_m1wait", m1_waitrequest, 1); chk("t6_rst_bbt", s_beginbursttransfer, 0);
    m0_write = 0;
    cyc();
    rst_n = 1;
    m0_address = 32'h900; m0_burstcount = 3'd2; m0_writedata = 32'h3; m0_write = 1;
    mid(); chk("t6_new_idle", s_write, 0); cyc();
    mid(); chk("t6_new_write", s_write, 1); chk("t6_new_bbt", s_beginbursttransfer, 1);
    chk("t6_new_addr", s_address, 32'h900); chk("t6_new_wait", m0_waitrequest, 0); cyc();
    m0_writedata = 32'h4;
    mid(); chk("t6_new_b2", s_write, 1); chk("t6_new_b2_bbt", s_beginbursttransfer, 0);
    chk("t6_new_b2_data", s_writedata, 32'h4); cyc();
    m0_write = 0;
    mid(); chk("t6_new_done", s_write, 0); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
